timer_alarm: RTL

- Compare/alarm stage directly downstream of timer_core's free-running 2*DATA_W time counter.
- Raises a level interrupt when the count reaches a programmed 64-bit compare value.
- Supports one-shot and periodic (auto-reload) modes, with a saturating missed-event counter.
- Control inputs are driven by the software register block; outputs are read back through it.

---
 rtl/timer_alarm_pkg.sv | 35 +++
 rtl/timer_alarm_if.sv | 44 ++++
 rtl/timer_alarm.sv | 89 ++++++++
 3 files changed

// File: rtl/timer_alarm_pkg.sv
// timer_alarm_pkg
//   Shared definitions for the timer compare/alarm stage: state encodings,
//   default widths and the software register map used by the register block
//   that drives the alarm's control inputs and reads back its status.
package timer_alarm_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int MISSED_W_DEF = 8;
    localparam int STATE_W      = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_e;

    // Software register byte offsets.
    localparam logic [7:0] REG_CMP_LOW  = 8'h00;
    localparam logic [7:0] REG_CMP_HIGH = 8'h04;
    localparam logic [7:0] REG_PERIOD   = 8'h08;
    localparam logic [7:0] REG_CTRL     = 8'h0C;
    localparam logic [7:0] REG_STATUS   = 8'h10;

    // CTRL bit positions (ARM/DISARM/ACK are write-one pulses, MODE is a level).
    localparam int CTRL_MODE_BIT   = 0;
    localparam int CTRL_ARM_BIT    = 1;
    localparam int CTRL_DISARM_BIT = 2;
    localparam int CTRL_ACK_BIT    = 3;

    // STATUS field positions.
    localparam int STATUS_IRQ_BIT   = 0;
    localparam int STATUS_STATE_LSB = 4;
    localparam int STATUS_MISSED_LSB = 8;

endpackage

// File: rtl/timer_alarm_if.sv
// timer_alarm_if
//   Bundle between the software register block (master) and the alarm stage
//   (slave), plus the live time count from timer_core.
//   Inputs to the alarm: TIMER_COUNT, CMP_WDATA, CMP_LOW_WEN, CMP_HIGH_WEN,
//   PERIOD, MODE, ARM, DISARM, ACK.
//   Outputs from the alarm: IRQ, MISSED, STATE, COMPARE (compare read-back).
//
//   Protocol: there is no valid/ready handshake. CMP_LOW_WEN, CMP_HIGH_WEN,
//   ARM, DISARM and ACK are single-cycle pulses acted on in the cycle they are
//   high; the alarm always accepts them. MODE and PERIOD are levels sampled
//   when a hit occurs. All outputs are registered.
interface timer_alarm_if #(
    parameter int DATA_W   = 32,
    parameter int MISSED_W = 8
);
    import timer_alarm_pkg::*;

    logic [2*DATA_W-1:0] TIMER_COUNT;
    logic [DATA_W-1:0]   CMP_WDATA;
    logic                CMP_LOW_WEN;
    logic                CMP_HIGH_WEN;
    logic [DATA_W-1:0]   PERIOD;
    logic                MODE;
    logic                ARM;
    logic                DISARM;
    logic                ACK;
    logic                IRQ;
    logic [MISSED_W-1:0] MISSED;
    logic [STATE_W-1:0]  STATE;
    logic [2*DATA_W-1:0] COMPARE;

    modport master (
        output TIMER_COUNT, CMP_WDATA, CMP_LOW_WEN, CMP_HIGH_WEN,
               PERIOD, MODE, ARM, DISARM, ACK,
        input  IRQ, MISSED, STATE, COMPARE
    );

    modport slave (
        input  TIMER_COUNT, CMP_WDATA, CMP_LOW_WEN, CMP_HIGH_WEN,
               PERIOD, MODE, ARM, DISARM, ACK,
        output IRQ, MISSED, STATE, COMPARE
    );

endinterface

// File: rtl/timer_alarm.sv
// timer_alarm
//   Compare/alarm stage fed by timer_core's free-running 2*DATA_W counter.
//   Raises a level interrupt (IRQ) when the count reaches the programmed
//   compare value; one-shot or periodic (auto-reload by PERIOD) operation,
//   with a saturating count of hits that land while IRQ is still pending.
//   Ports:
//     clk  - system clock
//     rst  - synchronous, active-high reset
//     bus  - timer_alarm_if.slave (controls in, IRQ/MISSED/STATE/COMPARE out)
module timer_alarm
    import timer_alarm_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MISSED_W = MISSED_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    timer_alarm_if.slave bus
);

    localparam logic [MISSED_W-1:0] MISSED_MAX = '1;

    state_e              state;
    logic [2*DATA_W-1:0] compare;
    logic [DATA_W-1:0]   shadow;
    logic                irq;
    logic [MISSED_W-1:0] missed;

    logic hit;
    logic fire;
    logic reload;

    // A compare already in the past fires as soon as the alarm is armed.
    assign hit    = (state == ARMED) && (bus.TIMER_COUNT >= compare);
    // DISARM in the hit cycle suppresses both the fire and the reload.
    assign fire   = hit && !bus.DISARM;
    // Periodic with a zero period would hit every cycle; treat it as one-shot.
    assign reload = fire && bus.MODE && (bus.PERIOD != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            compare <= '1;
            shadow  <= '0;
            irq     <= 1'b0;
            missed  <= '0;
        end else begin
            // High write commits {high, shadow} in one step so a half-updated
            // compare is never seen; it reads the shadow before any same-cycle
            // low write lands. A software write overrides the reload.
            if (bus.CMP_HIGH_WEN) begin
                compare <= {bus.CMP_WDATA, shadow};
            end else if (reload) begin
                compare <= compare + {{DATA_W{1'b0}}, bus.PERIOD};
            end

            if (bus.CMP_LOW_WEN) begin
                shadow <= bus.CMP_WDATA;
            end

            if (bus.DISARM) begin
                state <= IDLE;
            end else if (fire) begin
                state <= reload ? ARMED : FIRED;
            end else if (bus.ARM) begin
                state <= ARMED;
            end

            // A hit coinciding with ACK keeps the interrupt pending.
            if (fire) begin
                irq <= 1'b1;
            end else if (bus.ACK) begin
                irq <= 1'b0;
            end

            if (bus.ARM && !bus.DISARM) begin
                missed <= '0;
            end else if (fire && irq && !bus.ACK && (missed != MISSED_MAX)) begin
                missed <= missed + 1'b1;
            end
        end
    end

    assign bus.IRQ     = irq;
    assign bus.MISSED  = missed;
    assign bus.STATE   = state;
    assign bus.COMPARE = compare;

endmodule
